// File: rtl/lift_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// lift_scan_ctrl_if
// Button and status bundle between the floor/car button decoders, the lift
// controller and the floor indicator / door driver.
//
// Optional feature macro: LIFT_DOOR_HOLD_EN (adds door_hold_i after hall_dn).
//
// Signals:
//   car_req     [FLOORS]   car-panel buttons, bit i = floor i
//   hall_up     [FLOORS]   hall up-call buttons
//   hall_dn     [FLOORS]   hall down-call buttons
//   door_hold_i            door hold button (only with LIFT_DOOR_HOLD_EN)
//   elev_f_o    [FLOOR_W]  current floor
//   dir_o                  travel direction, 1 = up
//   moving_o               car travelling between floors
//   door_open_o            door open
//   busy_o                 controller active or calls pending
//   pending_o   [FLOORS]   latched calls per floor
// Modports: master = button side / observer, slave = controller.
// -----------------------------------------------------------------------------
interface lift_scan_ctrl_if #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = $clog2(FLOORS)
);
  logic [FLOORS-1:0]  car_req;
  logic [FLOORS-1:0]  hall_up;
  logic [FLOORS-1:0]  hall_dn;
`ifdef LIFT_DOOR_HOLD_EN
  logic               door_hold_i;
`endif
  logic [FLOOR_W-1:0] elev_f_o;
  logic               dir_o;
  logic               moving_o;
  logic               door_open_o;
  logic               busy_o;
  logic [FLOORS-1:0]  pending_o;

`ifdef LIFT_DOOR_HOLD_EN
  modport master (
    output car_req, hall_up, hall_dn, door_hold_i,
    input  elev_f_o, dir_o, moving_o, door_open_o, busy_o, pending_o
  );
  modport slave (
    input  car_req, hall_up, hall_dn, door_hold_i,
    output elev_f_o, dir_o, moving_o, door_open_o, busy_o, pending_o
  );
`else
  modport master (
    output car_req, hall_up, hall_dn,
    input  elev_f_o, dir_o, moving_o, door_open_o, busy_o, pending_o
  );
  modport slave (
    input  car_req, hall_up, hall_dn,
    output elev_f_o, dir_o, moving_o, door_open_o, busy_o, pending_o
  );
`endif
endinterface

// File: rtl/lift_scan_ctrl.sv
// -----------------------------------------------------------------------------
// lift_scan_ctrl
// Multi-floor elevator controller. Latches car and hall calls per floor and
// serves them in SCAN order (continue while calls remain ahead, then reverse).
// Floor position is tracked with a per-floor travel timer; the door runs a
// timed open cycle.
//
// Optional feature macro: LIFT_DOOR_HOLD_EN
//   defined   : bus.door_hold_i reloads the door timer while the door is open
//   undefined : fixed DOOR_CYC door time, no hold input
//
// Parameters: FLOORS (2..16), FLOOR_W, MOVE_CYC (cycles per floor),
//             DOOR_CYC (door open cycles)
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    lift_scan_ctrl_if.slave (buttons in, floor/door/status out)
// -----------------------------------------------------------------------------
module lift_scan_ctrl #(
  parameter int FLOORS   = 8,
  parameter int FLOOR_W  = $clog2(FLOORS),
  parameter int MOVE_CYC = 4,
  parameter int DOOR_CYC = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  lift_scan_ctrl_if.slave bus
);

  localparam int MC_W = (MOVE_CYC > 1) ? $clog2(MOVE_CYC) : 1;
  localparam int DC_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

  localparam logic [MC_W-1:0]    MOVE_LAST = MC_W'(MOVE_CYC - 1);
  localparam logic [DC_W-1:0]    DOOR_LAST = DC_W'(DOOR_CYC - 1);
  localparam logic [FLOOR_W-1:0] TOP_F     = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOOR_W-1:0] BOT_F     = {FLOOR_W{1'b0}};
  localparam logic [FLOORS-1:0]  ALL_ONES  = {FLOORS{1'b1}};
  localparam logic [FLOORS-1:0]  NONE      = {FLOORS{1'b0}};
  localparam logic [FLOORS-1:0]  ONE_HOT0  = {{(FLOORS-1){1'b0}}, 1'b1};
  // Top floor has no up call, ground floor has no down call.
  localparam logic [FLOORS-1:0]  UP_MASK   = ALL_ONES >> 1;
  localparam logic [FLOORS-1:0]  DN_MASK   = ALL_ONES << 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  // True when any call lies strictly beyond pos in the given direction.
  function automatic logic calls_ahead(input logic [FLOORS-1:0]  calls,
                                       input logic [FLOOR_W-1:0] pos,
                                       input logic               up);
    logic found;
    found = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (calls[i] && up && (i > int'(pos))) begin
        found = 1'b1;
      end else if (calls[i] && !up && (i < int'(pos))) begin
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return found;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [FLOOR_W-1:0] floor_r, floor_nxt_s, step_f_s;
  logic               dir_r, dir_nxt_s;
  logic [MC_W-1:0]    move_cnt_r, move_cnt_nxt_s;
  logic [DC_W-1:0]    door_cnt_r, door_cnt_nxt_s;
  logic [FLOORS-1:0]  car_r, up_r, dn_r;
  logic [FLOORS-1:0]  car_nxt_s, up_nxt_s, dn_nxt_s;
  logic [FLOORS-1:0]  pend_s, absorb_s, nxt_oh_s;
  logic [FLOORS-1:0]  clr_car_s, clr_up_s, clr_dn_s;
  logic               entry_s, ahead_after_s, hold_s;
  logic               moving_r, door_r, busy_r;
  logic [FLOORS-1:0]  pend_o_r;

`ifdef LIFT_DOOR_HOLD_EN
  assign hold_s = bus.door_hold_i;
`else
  assign hold_s = 1'b0;
`endif

  assign pend_s = car_r | up_r | dn_r;

  // Next-state, floor, direction and timer logic of the SCAN FSM.
  always_comb begin
    state_nxt_s    = state_r;
    floor_nxt_s    = floor_r;
    dir_nxt_s      = dir_r;
    move_cnt_nxt_s = move_cnt_r;
    door_cnt_nxt_s = door_cnt_r;
    step_f_s       = floor_r;
    case (state_r)
      ST_IDLE: begin
        move_cnt_nxt_s = {MC_W{1'b0}};
        door_cnt_nxt_s = {DC_W{1'b0}};
        if (pend_s[floor_r]) begin
          state_nxt_s = ST_DOOR;
        end else if (calls_ahead(pend_s, floor_r, dir_r)) begin
          state_nxt_s = ST_MOVE;
        end else if (calls_ahead(pend_s, floor_r, !dir_r)) begin
          state_nxt_s = ST_MOVE;
          dir_nxt_s   = !dir_r;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (move_cnt_r == MOVE_LAST) begin
          move_cnt_nxt_s = {MC_W{1'b0}};
          // Guarded step: never leave the shaft even if dir is stale.
          if (dir_r && (floor_r != TOP_F)) begin
            step_f_s = floor_r + FLOOR_W'(1);
          end else if (!dir_r && (floor_r != BOT_F)) begin
            step_f_s = floor_r - FLOOR_W'(1);
          end else begin
            step_f_s = floor_r;
          end
          floor_nxt_s = step_f_s;
          if (car_r[step_f_s] || (dir_r ? up_r[step_f_s] : dn_r[step_f_s]) ||
              !calls_ahead(pend_s, step_f_s, dir_r)) begin
            state_nxt_s = ST_DOOR;
          end else begin
            state_nxt_s = ST_MOVE;
          end
        end else begin
          move_cnt_nxt_s = move_cnt_r + MC_W'(1);
        end
      end
      ST_DOOR: begin
        if (hold_s) begin
          door_cnt_nxt_s = {DC_W{1'b0}};
        end else if (door_cnt_r == DOOR_LAST) begin
          door_cnt_nxt_s = {DC_W{1'b0}};
          if (calls_ahead(pend_s, floor_r, dir_r)) begin
            state_nxt_s = ST_MOVE;
          end else if (calls_ahead(pend_s, floor_r, !dir_r)) begin
            state_nxt_s = ST_MOVE;
            dir_nxt_s   = !dir_r;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          door_cnt_nxt_s = door_cnt_r + DC_W'(1);
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        move_cnt_nxt_s = {MC_W{1'b0}};
        door_cnt_nxt_s = {DC_W{1'b0}};
      end
    endcase
    // On departure the end floors pin the direction.
    if ((state_nxt_s == ST_MOVE) && (state_r != ST_MOVE)) begin
      if (floor_r == TOP_F) begin
        dir_nxt_s = 1'b0;
      end else if (floor_r == BOT_F) begin
        dir_nxt_s = 1'b1;
      end else begin
        dir_nxt_s = dir_nxt_s;
      end
    end else begin
      dir_nxt_s = dir_nxt_s;
    end
  end

  // Call latching with door-entry clears and in-door absorption.
  always_comb begin
    nxt_oh_s      = ONE_HOT0 << floor_nxt_s;
    entry_s       = (state_nxt_s == ST_DOOR) && (state_r != ST_DOOR);
    ahead_after_s = calls_ahead(pend_s, floor_nxt_s, dir_nxt_s);
    // While the door is open, new calls for this floor are already served.
    if (state_r == ST_DOOR) begin
      absorb_s = ~(ONE_HOT0 << floor_r);
    end else begin
      absorb_s = ALL_ONES;
    end
    clr_car_s = entry_s ? nxt_oh_s : NONE;
    if (entry_s && (dir_nxt_s || !ahead_after_s)) begin
      clr_up_s = nxt_oh_s;
    end else begin
      clr_up_s = NONE;
    end
    if (entry_s && (!dir_nxt_s || !ahead_after_s)) begin
      clr_dn_s = nxt_oh_s;
    end else begin
      clr_dn_s = NONE;
    end
    // Clear takes priority over a simultaneous set.
    car_nxt_s = (car_r | (bus.car_req & absorb_s)) & ~clr_car_s;
    up_nxt_s  = (up_r | (bus.hall_up & UP_MASK & absorb_s)) & ~clr_up_s;
    dn_nxt_s  = (dn_r | (bus.hall_dn & DN_MASK & absorb_s)) & ~clr_dn_s;
  end

  // State, call registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      floor_r    <= {FLOOR_W{1'b0}};
      dir_r      <= 1'b1;
      move_cnt_r <= {MC_W{1'b0}};
      door_cnt_r <= {DC_W{1'b0}};
      car_r      <= NONE;
      up_r       <= NONE;
      dn_r       <= NONE;
      moving_r   <= 1'b0;
      door_r     <= 1'b0;
      busy_r     <= 1'b0;
      pend_o_r   <= NONE;
    end else begin
      state_r    <= state_nxt_s;
      floor_r    <= floor_nxt_s;
      dir_r      <= dir_nxt_s;
      move_cnt_r <= move_cnt_nxt_s;
      door_cnt_r <= door_cnt_nxt_s;
      car_r      <= car_nxt_s;
      up_r       <= up_nxt_s;
      dn_r       <= dn_nxt_s;
      moving_r   <= (state_nxt_s == ST_MOVE);
      door_r     <= (state_nxt_s == ST_DOOR);
      busy_r     <= (state_nxt_s != ST_IDLE) || (|(car_nxt_s | up_nxt_s | dn_nxt_s));
      pend_o_r   <= car_nxt_s | up_nxt_s | dn_nxt_s;
    end
  end

  assign bus.elev_f_o    = floor_r;
  assign bus.dir_o       = dir_r;
  assign bus.moving_o    = moving_r;
  assign bus.door_open_o = door_r;
  assign bus.busy_o      = busy_r;
  assign bus.pending_o   = pend_o_r;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lift_scan_ctrl
// Directed self-checking bench for lift_scan_ctrl (FLOORS=8, MOVE_CYC=4,
// DOOR_CYC=6). Inputs are driven 1 time unit after the rising edge and outputs
// are sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_lift_scan_ctrl;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  lift_scan_ctrl_if #(.FLOORS(8), .FLOOR_W(3)) bus ();

  lift_scan_ctrl #(
    .FLOORS  (8),
    .FLOOR_W (3),
    .MOVE_CYC(4),
    .DOOR_CYC(6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.car_req = 8'($urandom);
    bus.hall_up = 8'($urandom);
    bus.hall_dn = 8'($urandom);
    tick(1);
    bus.car_req = 8'($urandom);
    bus.hall_up = 8'($urandom);
    bus.hall_dn = 8'($urandom);
    tick(1);
    n_assert++; if (bus.elev_f_o !== 3'd0) begin n_fail++; $display("FAIL reset_floor: got %0d exp 0", bus.elev_f_o); end
    n_assert++; if (bus.dir_o !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b exp 1", bus.dir_o); end
    n_assert++; if (bus.moving_o !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b exp 0", bus.moving_o); end
    n_assert++; if (bus.door_open_o !== 1'b0) begin n_fail++; $display("FAIL reset_door: got %b exp 0", bus.door_open_o); end
    n_assert++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy_o); end
    n_assert++; if (bus.pending_o !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h exp 00", bus.pending_o); end
    bus.car_req = 8'h00;
    bus.hall_up = 8'h00;
    bus.hall_dn = 8'h00;
    rst_n = 1'b1;
    tick(1);
    n_assert++; if (bus.pending_o !== 8'h00) begin n_fail++; $display("FAIL reset_release_pending: got %h exp 00", bus.pending_o); end
  endtask

  task automatic test_single_call();
    do_reset();
    bus.car_req = 8'h08;
    tick(1);                                  // E1: call latched
    bus.car_req = 8'h00;
    n_assert++; if (bus.pending_o !== 8'h08) begin n_fail++; $display("FAIL single_pending: got %h exp 08", bus.pending_o); end
    n_assert++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", bus.busy_o); end
    tick(1);                                  // E2: enters MOVE
    n_assert++; if (bus.moving_o !== 1'b1) begin n_fail++; $display("FAIL single_moving: got %b exp 1", bus.moving_o); end
    tick(3);                                  // E5: still floor 0
    n_assert++; if (bus.elev_f_o !== 3'd0) begin n_fail++; $display("FAIL single_floor0: got %0d exp 0", bus.elev_f_o); end
    tick(1);                                  // E6
    n_assert++; if (bus.elev_f_o !== 3'd1) begin n_fail++; $display("FAIL single_floor1: got %0d exp 1", bus.elev_f_o); end
    tick(4);                                  // E10
    n_assert++; if (bus.elev_f_o !== 3'd2) begin n_fail++; $display("FAIL single_floor2: got %0d exp 2", bus.elev_f_o); end
    tick(4);                                  // E14: arrive, door opens
    n_assert++; if (bus.elev_f_o !== 3'd3) begin n_fail++; $display("FAIL single_floor3: got %0d exp 3", bus.elev_f_o); end
    n_assert++; if ({bus.moving_o, bus.door_open_o} !== 2'b01) begin n_fail++; $display("FAIL single_arrive: got mv/door %b exp 01", {bus.moving_o, bus.door_open_o}); end
    n_assert++; if (bus.pending_o !== 8'h00) begin n_fail++; $display("FAIL single_cleared: got %h exp 00", bus.pending_o); end
    tick(5);                                  // E19: last door cycle
    n_assert++; if (bus.door_open_o !== 1'b1) begin n_fail++; $display("FAIL single_door_last: got %b exp 1", bus.door_open_o); end
    tick(1);                                  // E20: idle
    n_assert++; if ({bus.door_open_o, bus.moving_o, bus.busy_o} !== 3'b000) begin n_fail++; $display("FAIL single_idle: got door/mv/busy %b exp 000", {bus.door_open_o, bus.moving_o, bus.busy_o}); end
  endtask

  task automatic test_scan();
    do_reset();
    bus.car_req = 8'h20;
    tick(1);                                  // E1
    bus.car_req = 8'h00;
    tick(1);                                  // E2: MOVE
    bus.hall_up = 8'h04;
    bus.hall_dn = 8'h10;
    tick(1);                                  // E3: hall calls latched
    bus.hall_up = 8'h00;
    bus.hall_dn = 8'h00;
    n_assert++; if (bus.pending_o !== 8'h34) begin n_fail++; $display("FAIL scan_pending: got %h exp 34", bus.pending_o); end
    tick(7);                                  // E10: stop at 2
    n_assert++; if ({bus.elev_f_o, bus.door_open_o} !== {3'd2, 1'b1}) begin n_fail++; $display("FAIL scan_stop2: got floor %0d door %b exp 2/1", bus.elev_f_o, bus.door_open_o); end
    n_assert++; if (bus.pending_o !== 8'h30) begin n_fail++; $display("FAIL scan_clear_up2: got %h exp 30", bus.pending_o); end
    tick(6);                                  // E16: leave 2
    n_assert++; if ({bus.moving_o, bus.door_open_o} !== 2'b10) begin n_fail++; $display("FAIL scan_leave2: got mv/door %b exp 10", {bus.moving_o, bus.door_open_o}); end
    tick(8);                                  // E24: passing 4
    n_assert++; if ({bus.elev_f_o, bus.moving_o, bus.door_open_o} !== {3'd4, 2'b10}) begin n_fail++; $display("FAIL scan_skip4: got floor %0d mv/door %b exp 4/10", bus.elev_f_o, {bus.moving_o, bus.door_open_o}); end
    tick(4);                                  // E28: stop at 5
    n_assert++; if ({bus.elev_f_o, bus.door_open_o} !== {3'd5, 1'b1}) begin n_fail++; $display("FAIL scan_stop5: got floor %0d door %b exp 5/1", bus.elev_f_o, bus.door_open_o); end
    n_assert++; if (bus.pending_o !== 8'h10) begin n_fail++; $display("FAIL scan_pend5: got %h exp 10", bus.pending_o); end
    tick(6);                                  // E34: reverse
    n_assert++; if ({bus.dir_o, bus.moving_o} !== 2'b01) begin n_fail++; $display("FAIL scan_reverse: got dir/mv %b exp 01", {bus.dir_o, bus.moving_o}); end
    tick(4);                                  // E38: stop at 4
    n_assert++; if ({bus.elev_f_o, bus.door_open_o} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL scan_stop4: got floor %0d door %b exp 4/1", bus.elev_f_o, bus.door_open_o); end
    n_assert++; if (bus.pending_o !== 8'h00) begin n_fail++; $display("FAIL scan_clear_dn4: got %h exp 00", bus.pending_o); end
    tick(6);                                  // E44: idle
    n_assert++; if ({bus.door_open_o, bus.moving_o, bus.busy_o} !== 3'b000) begin n_fail++; $display("FAIL scan_idle: got door/mv/busy %b exp 000", {bus.door_open_o, bus.moving_o, bus.busy_o}); end
  endtask

  task automatic test_current_floor();
    do_reset();
    bus.car_req = 8'h01;
    tick(1);                                  // E1
    bus.car_req = 8'h00;
    n_assert++; if ({bus.pending_o, bus.door_open_o} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL cur_latch: got pend %h door %b exp 01/0", bus.pending_o, bus.door_open_o); end
    tick(1);                                  // E2: door opens in place
    n_assert++; if ({bus.door_open_o, bus.moving_o} !== 2'b10) begin n_fail++; $display("FAIL cur_door: got door/mv %b exp 10", {bus.door_open_o, bus.moving_o}); end
    n_assert++; if (bus.elev_f_o !== 3'd0) begin n_fail++; $display("FAIL cur_floor: got %0d exp 0", bus.elev_f_o); end
    tick(5);                                  // E7
    n_assert++; if ({bus.door_open_o, bus.pending_o} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL cur_door_last: got door %b pend %h exp 1/00", bus.door_open_o, bus.pending_o); end
    tick(1);                                  // E8
    n_assert++; if ({bus.door_open_o, bus.busy_o} !== 2'b00) begin n_fail++; $display("FAIL cur_idle: got door/busy %b exp 00", {bus.door_open_o, bus.busy_o}); end
  endtask

  task automatic test_masked();
    do_reset();
    bus.hall_up = 8'h80;
    bus.hall_dn = 8'h01;
    tick(1);
    bus.hall_up = 8'h00;
    bus.hall_dn = 8'h00;
    n_assert++; if (bus.pending_o !== 8'h00) begin n_fail++; $display("FAIL mask_pending: got %h exp 00", bus.pending_o); end
    tick(1);
    n_assert++; if ({bus.moving_o, bus.door_open_o, bus.busy_o} !== 3'b000) begin n_fail++; $display("FAIL mask_idle: got mv/door/busy %b exp 000", {bus.moving_o, bus.door_open_o, bus.busy_o}); end
    bus.car_req = 8'h80;
    tick(1);                                  // E1
    bus.car_req = 8'h00;
    tick(29);                                 // E30: arrive at top
    n_assert++; if ({bus.elev_f_o, bus.door_open_o} !== {3'd7, 1'b1}) begin n_fail++; $display("FAIL top_arrive: got floor %0d door %b exp 7/1", bus.elev_f_o, bus.door_open_o); end
    bus.car_req = 8'h80;                      // call for this floor while door open
    tick(1);
    bus.car_req = 8'h00;
    n_assert++; if ({bus.pending_o, bus.door_open_o} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL top_absorb: got pend %h door %b exp 00/1", bus.pending_o, bus.door_open_o); end
    tick(10);
    n_assert++; if ({bus.elev_f_o, bus.moving_o, bus.busy_o} !== {3'd7, 2'b00}) begin n_fail++; $display("FAIL top_stay: got floor %0d mv/busy %b exp 7/00", bus.elev_f_o, {bus.moving_o, bus.busy_o}); end
  endtask

  task automatic test_mid_move_reset();
    do_reset();
    bus.car_req = 8'h20;
    bus.hall_up = 8'h40;
    tick(1);                                  // E1
    bus.car_req = 8'h00;
    bus.hall_up = 8'h00;
    tick(9);                                  // E10: floor 2, moving
    n_assert++; if ({bus.elev_f_o, bus.moving_o} !== {3'd2, 1'b1}) begin n_fail++; $display("FAIL mid_pre: got floor %0d mv %b exp 2/1", bus.elev_f_o, bus.moving_o); end
    rst_n = 1'b0;
    tick(1);
    n_assert++; if ({bus.elev_f_o, bus.moving_o, bus.door_open_o} !== {3'd0, 2'b00}) begin n_fail++; $display("FAIL mid_reset_state: got floor %0d mv/door %b exp 0/00", bus.elev_f_o, {bus.moving_o, bus.door_open_o}); end
    n_assert++; if ({bus.pending_o, bus.busy_o, bus.dir_o} !== {8'h00, 2'b01}) begin n_fail++; $display("FAIL mid_reset_calls: got pend %h busy/dir %b exp 00/01", bus.pending_o, {bus.busy_o, bus.dir_o}); end
    rst_n = 1'b1;
    tick(3);
    n_assert++; if ({bus.moving_o, bus.busy_o} !== 2'b00) begin n_fail++; $display("FAIL mid_after: got mv/busy %b exp 00", {bus.moving_o, bus.busy_o}); end
  endtask

`ifdef LIFT_DOOR_HOLD_EN
  task automatic test_door_hold();
    int open_cnt;
    do_reset();
    bus.car_req = 8'h01;
    tick(1);                                  // E1
    bus.car_req = 8'h00;
    tick(1);                                  // E2: door opens
    open_cnt = bus.door_open_o ? 1 : 0;
    bus.door_hold_i = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (bus.door_open_o) open_cnt++;
      if (i == 10) bus.door_hold_i = 1'b0;
    end
    n_assert++; if (open_cnt !== 16) begin n_fail++; $display("FAIL door_hold_len: got %0d cycles exp 16", open_cnt); end
  endtask
`endif

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.car_req = 8'h00;
    bus.hall_up = 8'h00;
    bus.hall_dn = 8'h00;
`ifdef LIFT_DOOR_HOLD_EN
    bus.door_hold_i = 1'b0;
`endif
    tick(1);
    test_reset();
    test_single_call();
    test_scan();
    test_current_floor();
    test_masked();
    test_mid_move_reset();
`ifdef LIFT_DOOR_HOLD_EN
    test_door_hold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
